cpu_control: RTL and testbench

Control and execute stage of the Mini-CPU, directly upstream of the LCD driver. It latches an 18-bit instruction from the switches on a send-button press and runs it through a fetch/decode/execute sequence against a 16×16-bit register file. It then presents `opcode`, register indices, a sign-magnitude `result` and the CPU state code that the LCD stage consumes. It also handles power on/off and holds the SHOW state long enough for the LCD to finish its write sequence.

---
 rtl/cpu_control.sv | 200 ++++++++++++++++++++
 tb/tb_cpu_control.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control.sv
// Mini-CPU control/execute stage: button edge detection, FETCH/DECODE/EXEC/SHOW sequencing,
// 16x16 register file and sign-magnitude result for the LCD stage. Optional macro: MUL_SAT_EN.
module cpu_control #(
    parameter int SHOW_MIN = 4_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        power_btn,
    input  logic        send_btn,
    input  logic [17:0] instr,
    output logic [2:0]  opcode,
    output logic [3:0]  reg1,
    output logic [3:0]  reg2,
    output logic [3:0]  reg3,
    output logic [15:0] result,
    output logic [3:0]  estado_cpu
);

    localparam int CNT_W = (SHOW_MIN > 2) ? $clog2(SHOW_MIN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHOW_MIN - 1);

    localparam logic [2:0] OP_LOAD    = 3'd0;
    localparam logic [2:0] OP_ADD     = 3'd1;
    localparam logic [2:0] OP_ADDI    = 3'd2;
    localparam logic [2:0] OP_SUB     = 3'd3;
    localparam logic [2:0] OP_SUBI    = 3'd4;
    localparam logic [2:0] OP_MUL     = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    typedef enum logic [3:0] {
        S_OFF    = 4'd0,
        S_IDLE   = 4'd1,
        S_FETCH  = 4'd2,
        S_DECODE = 4'd3,
        S_EXEC   = 4'd4,
        S_SHOW   = 4'd5
    } state_t;

    state_t           state_reg;
    logic             power_q_reg;
    logic             send_q_reg;
    logic             power_ev_reg;
    logic             send_ev_reg;
    logic [17:0]      ir_reg;
    logic [15:0]      a_reg;
    logic [15:0]      b_reg;
    logic [15:0]      d_reg;
    logic [15:0]      imm_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [15:0]      rf [16];

    logic [2:0]         ir_op;
    logic [3:0]         ir_r1;
    logic [3:0]         ir_r2;
    logic [3:0]         ir_r3;
    logic               power_off;
    logic               exec_go;
    logic               rf_clear;
    logic               rf_we;
    logic signed [31:0] product;
    logic [15:0]        wb_value;
    logic [15:0]        neg_value;
    logic [15:0]        sm_value;

    assign ir_op = ir_reg[17:15];
    assign ir_r1 = ir_reg[14:11];
    assign ir_r2 = ir_reg[10:7];
    assign ir_r3 = ir_reg[6:3];

    // A power press while running aborts the instruction: EXEC never writes back in that cycle.
    assign power_off = power_ev_reg && (state_reg != S_OFF);
    assign exec_go   = (state_reg == S_EXEC) && !power_ev_reg;
    assign rf_clear  = power_off || (exec_go && ir_op == OP_CLEAR);
    assign rf_we     = exec_go && (ir_op != OP_CLEAR) && (ir_op != OP_DISPLAY);

    assign estado_cpu = state_reg;

    always_comb begin
        product  = $signed({{16{a_reg[15]}}, a_reg}) * $signed({{16{b_reg[15]}}, b_reg});
        wb_value = d_reg;
        case (ir_op)
            OP_LOAD: wb_value = imm_reg;
            OP_ADD:  wb_value = a_reg + b_reg;
            OP_ADDI: wb_value = a_reg + imm_reg;
            OP_SUB:  wb_value = a_reg - b_reg;
            OP_SUBI: wb_value = a_reg - imm_reg;
            OP_MUL: begin
`ifdef MUL_SAT_EN
                if (product > 32'sd32767)
                    wb_value = 16'h7FFF;
                else if (product < -32'sd32767)
                    wb_value = 16'h8001;
                else
                    wb_value = product[15:0];
`else
                wb_value = product[15:0];
`endif
            end
            default: wb_value = d_reg;
        endcase
    end

    // Two's complement to sign-magnitude; -32768 has no 15-bit magnitude and clamps to -32767.
    always_comb begin
        neg_value = -wb_value;
        sm_value  = wb_value;
        if (wb_value[15]) begin
            if (wb_value == 16'h8000)
                sm_value = 16'hFFFF;
            else
                sm_value = {1'b1, neg_value[14:0]};
        end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_rf
        always_ff @(posedge clk) begin
            if (!rst_n || rf_clear)
                rf[gi] <= '0;
            else if (rf_we && ir_r1 == 4'(gi))
                rf[gi] <= wb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_OFF;
            power_q_reg  <= 1'b0;
            send_q_reg   <= 1'b0;
            power_ev_reg <= 1'b0;
            send_ev_reg  <= 1'b0;
            ir_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            d_reg        <= '0;
            imm_reg      <= '0;
            cnt_reg      <= '0;
            opcode       <= '0;
            reg1         <= '0;
            reg2         <= '0;
            reg3         <= '0;
            result       <= '0;
        end else begin
            power_q_reg  <= power_btn;
            send_q_reg   <= send_btn;
            power_ev_reg <= power_btn & ~power_q_reg;
            send_ev_reg  <= send_btn & ~send_q_reg;

            if (power_off) begin
                state_reg <= S_OFF;
                cnt_reg   <= '0;
                opcode    <= '0;
                reg1      <= '0;
                reg2      <= '0;
                reg3      <= '0;
                result    <= '0;
            end else begin
                case (state_reg)
                    S_OFF: begin
                        if (power_ev_reg)
                            state_reg <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (send_ev_reg)
                            state_reg <= S_FETCH;
                    end
                    S_FETCH: begin
                        ir_reg    <= instr;
                        state_reg <= S_DECODE;
                    end
                    S_DECODE: begin
                        a_reg     <= rf[ir_r2];
                        b_reg     <= rf[ir_r3];
                        d_reg     <= rf[ir_r1];
                        imm_reg   <= {{9{ir_reg[6]}}, ir_reg[6:0]};
                        state_reg <= S_EXEC;
                    end
                    S_EXEC: begin
                        opcode    <= ir_op;
                        reg1      <= ir_r1;
                        reg2      <= ir_r2;
                        reg3      <= ir_r3;
                        result    <= (ir_op == OP_CLEAR) ? 16'h0000 : sm_value;
                        cnt_reg   <= '0;
                        state_reg <= S_SHOW;
                    end
                    S_SHOW: begin
                        // Sends arriving before the LCD has had its hold time are dropped, not queued.
                        if (cnt_reg != CNT_LAST)
                            cnt_reg <= cnt_reg + 1'b1;
                        else if (send_ev_reg)
                            state_reg <= S_FETCH;
                    end
                    default: state_reg <= S_OFF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: directed scenarios plus randomized instructions
// checked against an arithmetic reference model of the instruction set.
module tb_cpu_control;

    localparam int SHOW_MIN = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        power_btn;
    logic        send_btn;
    logic [17:0] instr;
    logic [2:0]  opcode;
    logic [3:0]  reg1;
    logic [3:0]  reg2;
    logic [3:0]  reg3;
    logic [15:0] result;
    logic [3:0]  estado_cpu;

    cpu_control #(.SHOW_MIN(SHOW_MIN)) dut (
        .clk(clk), .rst_n(rst_n), .power_btn(power_btn), .send_btn(send_btn),
        .instr(instr), .opcode(opcode), .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .result(result), .estado_cpu(estado_cpu)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int m_rf [16];
    bit m_show;
    int show_cyc;
    int e_op, e_r1, e_r2, e_r3, e_res;

    function automatic int wrap16(input int x);
        int y;
        y = x & 32'hFFFF;
        if (y > 32767) y = y - 65536;
        return y;
    endfunction

    function automatic int sext7(input int x);
        int y;
        y = x & 127;
        if (y > 63) y = y - 128;
        return y;
    endfunction

    function automatic int to_sm(input int v);
        int m;
        if (v < 0) begin
            m = -v;
            if (m > 32767) m = 32767;
            return 32768 + m;
        end
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 16; k++) m_rf[k] = 0;
        e_op = 0; e_r1 = 0; e_r2 = 0; e_r3 = 0; e_res = 0;
        m_show = 1'b0;
    endtask

    task automatic model_exec(input logic [17:0] i);
        int op, d, s1, s2, a, b, imm, v, p;
        op = int'(i[17:15]); d = int'(i[14:11]); s1 = int'(i[10:7]); s2 = int'(i[6:3]);
        a = m_rf[s1]; b = m_rf[s2]; imm = sext7(int'(i[6:0]));
        v = 0;
        case (op)
            0: v = imm;
            1: v = wrap16(a + b);
            2: v = wrap16(a + imm);
            3: v = wrap16(a - b);
            4: v = wrap16(a - imm);
            5: begin
                p = a * b;
`ifdef MUL_SAT_EN
                if (p > 32767) v = 32767;
                else if (p < -32767) v = -32767;
                else v = p;
`else
                v = wrap16(p);
`endif
            end
            default: v = m_rf[d];
        endcase
        if (op == 6) begin
            for (int k = 0; k < 16; k++) m_rf[k] = 0;
            e_res = 0;
        end else begin
            if (op != 7) m_rf[d] = v;
            e_res = to_sm(v);
        end
        e_op = op; e_r1 = d; e_r2 = s1; e_r3 = s2;
    endtask

    // Press send at the earliest accepted moment and return once the DUT should be in SHOW.
    task automatic run_instr(input logic [17:0] i);
        while (m_show && cyc < show_cyc + SHOW_MIN - 2) @(negedge clk);
        instr = i;
        send_btn = 1'b1;
        @(negedge clk);
        send_btn = 1'b0;
        repeat (4) @(negedge clk);
        show_cyc = cyc;
        m_show = 1'b1;
        model_exec(i);
    endtask

    task automatic press_power();
        power_btn = 1'b1;
        @(negedge clk);
        power_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; power_btn = 1'b0; send_btn = 1'b0; instr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (estado_cpu !== 4'd0) $display("FAIL reset_state: got %0d expected 0", estado_cpu);
        else passes++;
        checks++;
        if ({opcode, reg1, reg2, reg3, result} !== 31'd0)
            $display("FAIL reset_outputs: got %h expected 0", {opcode, reg1, reg2, reg3, result});
        else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        model_clear();
    endtask

    task automatic test_power_on();
        instr = 18'h01_805;
        send_btn = 1'b1;
        @(negedge clk);
        send_btn = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (estado_cpu !== 4'd0) $display("FAIL send_in_off: got %0d expected 0", estado_cpu);
        else passes++;
        press_power();
        checks++;
        if (estado_cpu !== 4'd1) $display("FAIL power_on: got %0d expected 1", estado_cpu);
        else passes++;
    endtask

    task automatic test_load();
        logic [17:0] i;
        logic [3:0]  exp_seq [4];
        exp_seq[0] = 4'd1; exp_seq[1] = 4'd2; exp_seq[2] = 4'd3; exp_seq[3] = 4'd4;
        i = {3'd0, 4'd1, 4'd0, 7'd5};
        instr = i;
        send_btn = 1'b1;
        @(negedge clk);
        send_btn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (estado_cpu !== exp_seq[k] || result !== 16'h0000)
                $display("FAIL load_seq%0d: got state %0d result %h expected state %0d result 0000",
                         k, estado_cpu, result, exp_seq[k]);
            else passes++;
            @(negedge clk);
        end
        show_cyc = cyc; m_show = 1'b1;
        model_exec(i);
        checks++;
        if (estado_cpu !== 4'd5 || result !== 16'h0005 || opcode !== 3'd0 || reg1 !== 4'd1)
            $display("FAIL load_show: got state %0d result %h op %0d r1 %0d expected 5 0005 0 1",
                     estado_cpu, result, opcode, reg1);
        else passes++;
        $display("instr %05h -> result %04h", i, result);
    endtask

    task automatic test_sub();
        run_instr({3'd0, 4'd2, 4'd0, 7'd7});
        run_instr({3'd3, 4'd3, 4'd1, 4'd2, 3'd0});
        $display("instr SUB r3,r1,r2 -> result %04h", result);
        checks++;
        if (result !== 16'h8002 || result !== 16'(e_res) || reg3 !== 4'd2)
            $display("FAIL sub: got result %h reg3 %0d expected 8002 2", result, reg3);
        else passes++;
        run_instr({3'd7, 4'd3, 11'd0});
        checks++;
        if (result !== 16'h8002) $display("FAIL sub_display: got %h expected 8002", result);
        else passes++;
    endtask

    task automatic test_mul();
        logic [15:0] want;
`ifdef MUL_SAT_EN
        want = 16'h7FFF;
`else
        want = 16'h5F90;
`endif
        run_instr({3'd0, 4'd5, 4'd0, 7'd20});
        run_instr({3'd0, 4'd6, 4'd0, 7'd15});
        run_instr({3'd5, 4'd1, 4'd5, 4'd6, 3'd0});
        checks++;
        if (result !== 16'd300) $display("FAIL mul_300: got %h expected 012c", result);
        else passes++;
        run_instr({3'd5, 4'd2, 4'd5, 4'd6, 3'd0});
        run_instr({3'd5, 4'd4, 4'd1, 4'd2, 3'd0});
        $display("instr MUL r4,r1,r2 -> result %04h", result);
        checks++;
        if (result !== want || result !== 16'(e_res))
            $display("FAIL mul: got %h expected %h", result, want);
        else passes++;
        run_instr({3'd7, 4'd4, 11'd0});
        checks++;
        if (result !== want) $display("FAIL mul_display: got %h expected %h", result, want);
        else passes++;
    endtask

    // Pulses send so the FSM sees the event on the edge show_cyc+exit_k (SHOW entered at show_cyc).
    task automatic test_show_hold();
        // exit edge 100: dropped
        while (cyc < show_cyc + 98) @(negedge clk);
        instr = {3'd7, 4'd1, 11'd0};
        send_btn = 1'b1; @(negedge clk); send_btn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (estado_cpu !== 4'd5) $display("FAIL show_early100: got %0d expected 5", estado_cpu);
        else passes++;
        // exit edge SHOW_MIN: accepted
        while (cyc < show_cyc + SHOW_MIN - 2) @(negedge clk);
        send_btn = 1'b1; @(negedge clk); send_btn = 1'b0;
        checks++;
        if (estado_cpu !== 4'd5) $display("FAIL show_pending: got %0d expected 5", estado_cpu);
        else passes++;
        @(negedge clk);
        checks++;
        if (estado_cpu !== 4'd2) $display("FAIL show_accept: got %0d expected 2", estado_cpu);
        else passes++;
        repeat (3) @(negedge clk);
        show_cyc = cyc;
        model_exec(instr);
        checks++;
        if (estado_cpu !== 4'd5 || result !== 16'(e_res))
            $display("FAIL show_exec: got state %0d result %h expected 5 %h", estado_cpu, result, 16'(e_res));
        else passes++;
        // exit edge SHOW_MIN-1: one cycle too early, dropped
        while (cyc < show_cyc + SHOW_MIN - 3) @(negedge clk);
        send_btn = 1'b1; @(negedge clk); send_btn = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (estado_cpu !== 4'd5) $display("FAIL show_early199: got %0d expected 5", estado_cpu);
        else passes++;
    endtask

    task automatic test_hold_send();
        int  n_exec;
        bit  seen;
        logic [17:0] i;
        i = {3'd2, 4'd8, 4'd8, 7'd1};
        n_exec = 0; seen = 1'b0;
        while (cyc < show_cyc + SHOW_MIN - 2) @(negedge clk);
        instr = i;
        send_btn = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (estado_cpu == 4'd4) n_exec++;
            if (estado_cpu == 4'd5 && n_exec == 1 && !seen) begin
                seen = 1'b1;
                show_cyc = cyc;
            end
        end
        send_btn = 1'b0;
        @(negedge clk);
        model_exec(i);
        checks++;
        if (n_exec !== 1) $display("FAIL hold_send: got %0d executions expected 1", n_exec);
        else passes++;
        checks++;
        if (estado_cpu !== 4'd5 || result !== 16'(e_res))
            $display("FAIL hold_result: got state %0d result %h expected 5 %h", estado_cpu, result, 16'(e_res));
        else passes++;
    endtask

    task automatic test_clear();
        for (int k = 1; k <= 4; k++)
            run_instr({3'd0, 4'(k), 4'd0, 7'($urandom_range(1, 127))});
        run_instr({3'd6, 15'd0});
        checks++;
        if (result !== 16'h0000 || opcode !== 3'd6)
            $display("FAIL clear: got result %h op %0d expected 0000 6", result, opcode);
        else passes++;
        for (int k = 1; k <= 4; k++) begin
            run_instr({3'd7, 4'(k), 11'd0});
            checks++;
            if (result !== 16'h0000) $display("FAIL clear_display_r%0d: got %h expected 0000", k, result);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic [17:0] i;
        for (int k = 1; k < 16; k++) run_instr({3'd0, 4'(k), 4'd0, 7'($urandom)});
        for (int n = 0; n < 25; n++) begin
            i = 18'($urandom);
            if (i[17:15] == 3'd6 && ($urandom_range(0, 3) != 0)) i[17:15] = 3'd5;
            run_instr(i);
            $display("instr %05h op %0d -> result %04h (model %04h)", i, opcode, result, 16'(e_res));
            checks++;
            if (result !== 16'(e_res)) $display("FAIL rand_result%0d: got %h expected %h", n, result, 16'(e_res));
            else passes++;
            checks++;
            if ({opcode, reg1, reg2, reg3} !== {3'(e_op), 4'(e_r1), 4'(e_r2), 4'(e_r3)})
                $display("FAIL rand_fields%0d: got %h expected %h", n, {opcode, reg1, reg2, reg3},
                         {3'(e_op), 4'(e_r1), 4'(e_r2), 4'(e_r3)});
            else passes++;
        end
    endtask

    task automatic test_power_send_same();
        press_power();
        model_clear();
        checks++;
        if (estado_cpu !== 4'd0 || {opcode, reg1, reg2, reg3, result} !== 31'd0)
            $display("FAIL power_off: got state %0d outputs %h expected 0 0", estado_cpu,
                     {opcode, reg1, reg2, reg3, result});
        else passes++;
        press_power();
        checks++;
        if (estado_cpu !== 4'd1) $display("FAIL repower: got %0d expected 1", estado_cpu);
        else passes++;
        instr = {3'd0, 4'd1, 4'd0, 7'd9};
        power_btn = 1'b1; send_btn = 1'b1;
        @(negedge clk);
        power_btn = 1'b0; send_btn = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (estado_cpu !== 4'd0 || {opcode, reg1, reg2, reg3, result} !== 31'd0)
            $display("FAIL power_send_same: got state %0d outputs %h expected 0 0", estado_cpu,
                     {opcode, reg1, reg2, reg3, result});
        else passes++;
        press_power();
        run_instr({3'd7, 4'd1, 11'd0});
        checks++;
        if (result !== 16'h0000 || estado_cpu !== 4'd5)
            $display("FAIL display_after_off: got result %h state %0d expected 0000 5", result, estado_cpu);
        else passes++;
    endtask

    task automatic test_reset_mid();
        run_instr({3'd0, 4'd9, 4'd0, 7'd33});
        checks++;
        if (result !== 16'd33) $display("FAIL load_r9: got %h expected 0021", result);
        else passes++;
        while (cyc < show_cyc + SHOW_MIN - 2) @(negedge clk);
        instr = {3'd2, 4'd10, 4'd9, 7'd1};
        send_btn = 1'b1; @(negedge clk); send_btn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (estado_cpu !== 4'd3) $display("FAIL reach_decode: got %0d expected 3", estado_cpu);
        else passes++;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (estado_cpu !== 4'd0 || {opcode, reg1, reg2, reg3, result} !== 31'd0)
            $display("FAIL reset_mid: got state %0d outputs %h expected 0 0", estado_cpu,
                     {opcode, reg1, reg2, reg3, result});
        else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        model_clear();
        press_power();
        run_instr({3'd7, 4'd9, 11'd0});
        checks++;
        if (result !== 16'h0000) $display("FAIL r9_after_reset: got %h expected 0000", result);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_load();
        test_sub();
        test_mul();
        test_show_hold();
        test_hold_send();
        test_clear();
        test_random();
        test_power_send_same();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
